// File: rtl/csa_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : csa_mult_seq_ctrl
//  Purpose  : Sequencing controller for an iterative unsigned multiply built
//             around one external combinational 32-bit 3:2 carry-save adder.
//             Each ACCUM cycle folds one shifted partial product into the
//             sum/carry pair; one RESOLVE cycle adds them into the product.
//  Ports    : clk, reset (async, active-high)
//             start, a, b        - request and captured operands
//             busy, done         - handshake (done is a one-cycle pulse)
//             product            - 32-bit result, held until next resolve
//             csa_x/y/z          - operands presented to the external CSA
//             csa_s/c            - CSA results (carry already shifted left)
//  Revision : 1.0  initial release
// ============================================================================
module csa_mult_seq_ctrl #(
  parameter int          WIDTH      = 16,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [31:0]      product,
  output logic [31:0]      csa_x,
  output logic [31:0]      csa_y,
  output logic [31:0]      csa_z,
  input  logic [31:0]      csa_s,
  input  logic [31:0]      csa_c
);

  localparam logic [1:0] c_S_IDLE    = 2'd0;
  localparam logic [1:0] c_S_ACCUM   = 2'd1;
  localparam logic [1:0] c_S_RESOLVE = 2'd2;

  localparam logic [4:0] c_LAST = 5'(WIDTH - 1);
  localparam bit         c_EE   = (EARLY_EXIT != 0);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [31:0]      r_sum;
  logic [31:0]      r_carry;
  logic [4:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [31:0]      r_product;

  logic [WIDTH-1:0] w_b_shift;
  logic             w_bbit;
  logic             w_more;
  logic             w_b_zero;
  logic [31:0]      w_a_ext;
  logic [31:0]      w_pp;

  // Shifting b down by cnt gives both the current multiplier bit (bit 0)
  // and whether any higher bit remains (the rest), without a variable index.
  assign w_b_shift = r_b >> r_cnt;
  assign w_bbit    = w_b_shift[0];
  assign w_more    = |(w_b_shift >> 1);
  assign w_b_zero  = (b == '0);
  assign w_a_ext   = {{(32-WIDTH){1'b0}}, r_a};
  assign w_pp      = w_bbit ? (w_a_ext << r_cnt) : 32'd0;

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (start) begin
          // Zero multiplier needs no accumulation when early exit is enabled
          w_state_nxt = (c_EE && w_b_zero) ? c_S_RESOLVE : c_S_ACCUM;
        end
      end
      c_S_ACCUM: begin
        if ((r_cnt == c_LAST) || (c_EE && !w_more)) begin
          w_state_nxt = c_S_RESOLVE;
        end
      end
      c_S_RESOLVE: w_state_nxt = c_S_IDLE;
      default:     w_state_nxt = c_S_IDLE;
    endcase
  end

  // CSA operand outputs: only meaningful while accumulating
  always_comb begin
    csa_x = 32'd0;
    csa_y = 32'd0;
    csa_z = 32'd0;
    if (r_state == c_S_ACCUM) begin
      csa_x = r_sum;
      csa_y = r_carry;
      csa_z = w_pp;
    end
  end

  // Datapath and handshake registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= 32'd0;
      r_carry   <= 32'd0;
      r_cnt     <= 5'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= 32'd0;
            r_carry <= 32'd0;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b1;
          end
        end
        c_S_ACCUM: begin
          r_sum   <= csa_s;
          r_carry <= csa_c;
          r_cnt   <= r_cnt + 5'd1;
        end
        c_S_RESOLVE: begin
          r_product <= r_sum + r_carry;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csa_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csa_mult_seq_ctrl
//  Purpose  : Self-checking bench. Two controllers (EARLY_EXIT=0 and 1) share
//             the same stimulus, each driving its own behavioural 3:2 CSA.
//             Expected products and done cycles are queued at issue time and
//             popped when done pulses; the carry-save invariant and partial
//             products are checked every ACCUM cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csa_mult_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;

  logic        busy_w [2];
  logic        done_w [2];
  logic [31:0] prod   [2];
  logic [31:0] cx     [2];
  logic [31:0] cy     [2];
  logic [31:0] cz     [2];
  logic [31:0] cs     [2];
  logic [31:0] cc     [2];

  typedef struct {
    logic [31:0] p;
    int          c;
  } exp_t;

  exp_t q0 [$];
  exp_t q1 [$];

  int total;
  int passes;
  int fails;
  int cyc;

  bit          act [2];
  int          j   [2];
  int          k   [2];
  logic [31:0] ca  [2];
  logic [31:0] cb  [2];

  csa_mult_seq_ctrl #(.WIDTH(16), .EARLY_EXIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy_w[0]), .done(done_w[0]), .product(prod[0]),
    .csa_x(cx[0]), .csa_y(cy[0]), .csa_z(cz[0]),
    .csa_s(cs[0]), .csa_c(cc[0])
  );

  csa_mult_seq_ctrl #(.WIDTH(16), .EARLY_EXIT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy_w[1]), .done(done_w[1]), .product(prod[1]),
    .csa_x(cx[1]), .csa_y(cy[1]), .csa_z(cz[1]),
    .csa_s(cs[1]), .csa_c(cc[1])
  );

  // Behavioural 3:2 compressor, carry shifted left with bit 31 carry dropped
  assign cs[0] = cx[0] ^ cy[0] ^ cz[0];
  assign cc[0] = ((cx[0] & cy[0]) | (cx[0] & cz[0]) | (cy[0] & cz[0])) << 1;
  assign cs[1] = cx[1] ^ cy[1] ^ cz[1];
  assign cc[1] = ((cx[1] & cy[1]) | (cx[1] & cz[1]) | (cy[1] & cz[1])) << 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int kof(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 16; i++) if (v[i]) r = i + 1;
    return r;
  endfunction

  // Called right after a negedge with both controllers able to accept.
  // Returns at the negedge following the accept edge (cnt=0 cycle).
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib);
    exp_t e;
    int   k1;
    k1    = kof(ib);
    start = 1'b1;
    a     = ia;
    b     = ib;
    e.p   = 32'(ia) * 32'(ib);
    e.c   = cyc + 16 + 2;
    q0.push_back(e);
    e.c   = cyc + k1 + 2;
    q1.push_back(e);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b1;
      j[d]   = 0;
      ca[d]  = 32'(ia);
      cb[d]  = 32'(ib);
    end
    k[0] = 16;
    k[1] = k1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || act[0] || act[1]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(n < 100), 64'd1);
  endtask

  // Per-cycle monitor: accumulation invariant and scoreboard pop on done
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [63:0] mask;
      logic [63:0] full;
      logic [31:0] acc;
      logic [31:0] pp;
      exp_t        e;
      if (act[d]) begin
        if (j[d] < k[d]) begin
          mask = (64'd1 << j[d]) - 64'd1;
          full = 64'(ca[d]) * (64'(cb[d]) & mask);
          acc  = cx[d] + cy[d];
          pp   = cb[d][j[d]] ? (ca[d] << j[d]) : 32'd0;
          chk("cs_invariant", 64'(acc), 64'(full[31:0]));
          chk("csa_z", 64'(cz[d]), 64'(pp));
          chk("busy_accum", 64'(busy_w[d]), 64'd1);
        end else begin
          chk("csa_resolve_zero", 64'(cx[d] | cy[d] | cz[d]), 64'd0);
          chk("busy_resolve", 64'(busy_w[d]), 64'd1);
          act[d] = 1'b0;
        end
        j[d]++;
      end
      if (done_w[d]) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          chk("done_unexpected", 64'(done_w[d]), 64'd0);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("product", 64'(prod[d]), 64'(e.p));
          chk("done_cycle", 64'(cyc), 64'(e.c));
          chk("busy_at_done", 64'(busy_w[d]), 64'd0);
        end
      end
    end
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    total  = 0;
    passes = 0;
    fails  = 0;
    act[0] = 1'b0;
    act[1] = 1'b0;
    reset  = 1'b1;
    start  = 1'b0;
    a      = 16'd0;
    b      = 16'd0;

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", 64'(busy_w[d]), 64'd0);
      chk("rst_done", 64'(done_w[d]), 64'd0);
      chk("rst_product", 64'(prod[d]), 64'd0);
      chk("rst_csa", 64'(cx[d] | cy[d] | cz[d]), 64'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Basic small operands
    issue(16'd3, 16'd5);
    wait_idle();

    // Full-scale operands
    issue(16'hFFFF, 16'hFFFF);
    wait_idle();

    // Zero multiplier, then single-bit multiplier
    issue(16'h1234, 16'h0000);
    wait_idle();
    issue(16'h1234, 16'h0001);
    wait_idle();

    // Start pulsed during ACCUM is ignored
    issue(16'd7, 16'd9);
    @(negedge clk);
    start = 1'b1;
    a     = 16'd2;
    b     = 16'd2;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Back-to-back: new start presented in the done cycle
    issue(16'h1111, 16'h8001);
    for (int i = 0; i < 40 && !done_w[0]; i++) @(negedge clk);
    chk("b2b_done_seen", 64'(done_w[0]), 64'd1);
    issue(16'h00FF, 16'h8003);
    wait_idle();

    // Reset mid-operation at cnt=5
    issue(16'hAAAA, 16'h5555);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("abort_busy", 64'(busy_w[d]), 64'd0);
      chk("abort_done", 64'(done_w[d]), 64'd0);
      chk("abort_product", 64'(prod[d]), 64'd0);
      chk("abort_csa", 64'(cx[d] | cy[d] | cz[d]), 64'd0);
    end
    act[0] = 1'b0;
    act[1] = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_abort_idle0", 64'(busy_w[0]), 64'd0);
    chk("post_abort_idle1", 64'(busy_w[1]), 64'd0);
    issue(16'hAAAA, 16'h5555);
    wait_idle();

    // Random sweep with varied multiplier magnitude
    for (int n = 0; n < 2000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom >> $urandom_range(16, 31));
      issue(ra, rb);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    chk("queues_empty", 64'(q0.size() + q1.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
